dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Parametrised successor to the processor's data-cache stage: a direct-mapped, write-through, read-allocate data cache with a handshaked backing-memory port.
- Sits between the ALU/MemRead/MemWrite outputs (CPU side) and a slower main memory (memory side).
- Adds hit/miss detection, miss stalls, flush and hit/miss statistics counters.

Parameters:
- ADDR_WIDTH, 32, byte address width; addr[1:0] ignored (word-aligned).
- DATA_WIDTH, 32, word width.
- LINES, 16, number of one-word lines. Must be a power of two. INDEX_BITS = $clog2(LINES); TAG_BITS = ADDR_WIDTH-2-INDEX_BITS.
- CNT_WIDTH, 16, width of the hit and miss counters.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- cpu_read  in  1  load request (MemRead)
- cpu_write  in  1  store request (MemWrite)
- cpu_addr  in  ADDR_WIDTH  byte address (ALU_Result)
- cpu_wdata  in  DATA_WIDTH  store data (Read_data2)
- flush  in  1  invalidate all lines
- cpu_rdata  out  DATA_WIDTH  load data; valid when cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- cpu_busy  out  1  request in progress; new requests ignored
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1=write, 0=read
- mem_addr  out  ADDR_WIDTH  word-aligned address (low 2 bits 0)
- mem_wdata  out  DATA_WIDTH  write data
- mem_ready  in  1  memory completion; mem_rdata valid same cycle
- mem_rdata  in  DATA_WIDTH  memory read data
- hit_count  out  CNT_WIDTH  saturating count of hits
- miss_count  out  CNT_WIDTH  saturating count of misses

Behaviour:
- Reset (synchronous, active-high, clock edge):
  - State goes to IDLE; all valid bits cleared.
  - cpu_rdata=0, cpu_ready=0, cpu_busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, hit_count=0, miss_count=0.
  - Reset in any state aborts the operation; mem_req is low from the next cycle.
- Address split: index=cpu_addr[INDEX_BITS+1:2]; tag=cpu_addr[ADDR_WIDTH-1:INDEX_BITS+2].
  - Hit = valid[index] && tag_store[index]==tag.
- States: IDLE, READ_MEM, WRITE_MEM, RESPOND. All outputs are registered.
- IDLE, priority flush > write > read:
  - flush: clear all valid bits in one cycle; no cpu_ready; counters unchanged; stay in IDLE.
  - Write (cpu_write=1, including cpu_read=1 simultaneously, which counts as a write): latch addr/wdata.
    - On a hit, update the line data and count a hit; on a miss, count a miss and do not allocate.
    - Go to WRITE_MEM with mem_req=1, mem_we=1, mem_addr, mem_wdata.
  - Read hit: cpu_rdata=line data, count a hit, go to RESPOND. Latency: cpu_ready one cycle after acceptance.
  - Read miss: count a miss, go to READ_MEM with mem_req=1, mem_we=0, mem_addr=aligned address.
  - cpu_busy=1 from the cycle after acceptance until the RESPOND cycle (inclusive).
- READ_MEM: hold mem_req, mem_addr and mem_we until mem_ready=1. On that edge:
  - Write mem_rdata into the line; set valid and tag.
  - cpu_rdata=mem_rdata; mem_req=0; go to RESPOND.
- WRITE_MEM: hold until mem_ready=1, then mem_req=0, mem_we=0, go to RESPOND.
- RESPOND: cpu_ready=1 for exactly one cycle, then IDLE with cpu_busy=0.
  - A request present during RESPOND is ignored; the CPU re-presents it in IDLE.
- cpu_read, cpu_write and flush are ignored outside IDLE; the requester holds them until accepted.
- Counters saturate at 2^CNT_WIDTH-1; no wrap.
- cpu_rdata holds its last value between responses; it is not updated on writes.
- mem_ready while mem_req=0 is ignored.

Test Plan:
- Reset, then read 0x40, memory answers 0xDEADBEEF after 3 cycles -> mem_req high 3 cycles with mem_addr=0x40, mem_we=0; cpu_ready one cycle later with cpu_rdata=0xDEADBEEF; miss_count=1.
- Re-read 0x40, then 0x42 -> each completes with cpu_ready 1 cycle after acceptance, data 0xDEADBEEF, no mem_req; hit_count=2.
- Read 0x440 (index 0 with LINES=16, tag differs) -> miss, line refilled; a subsequent read of 0x40 misses again.
- Write 0x12345678 to 0x40 while resident -> mem_req/mem_we=1 to 0x40 until mem_ready; a following read of 0x40 hits with 0x12345678. Write to non-resident 0x80 -> miss, no allocate, so a later read of 0x80 misses.
- flush in IDLE, then read 0x40 -> miss. flush and cpu_read asserted together -> flush only, no cpu_ready.
- Assert reset while in READ_MEM -> mem_req=0 the next cycle, counters 0, all lines invalid. Preload CNT_WIDTH=4 with 16 hits -> hit_count stays 15.

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, read-allocate data cache with a handshaked backing-memory port.
// Read hit: cpu_ready 1 cycle after acceptance. Misses and writes stall, with cpu_busy high, until mem_ready.
module dcache_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINES      = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic                  cpu_busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int INDEX_BITS = $clog2(LINES);
  localparam int TAG_BITS   = ADDR_WIDTH - 2 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, READ_MEM, WRITE_MEM, RESPOND} state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_store  [LINES];
  logic [DATA_WIDTH-1:0] data_store [LINES];

  logic [INDEX_BITS-1:0] cpu_index, mem_index;
  logic [TAG_BITS-1:0]   cpu_tag, mem_tag;
  logic                  hit;
  logic                  unused_addr_bits;

  assign cpu_index        = cpu_addr[INDEX_BITS+1:2];
  assign cpu_tag          = cpu_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign mem_index        = mem_addr[INDEX_BITS+1:2];
  assign mem_tag          = mem_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign hit              = valid[cpu_index] && (tag_store[cpu_index] == cpu_tag);
  assign unused_addr_bits = ^{cpu_addr[1:0], mem_addr[1:0]};

  logic [DATA_WIDTH-1:0] rdata_nxt, wdata_nxt, line_dat;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  ready_nxt, busy_nxt, req_nxt, we_nxt;
  logic                  line_we, set_valid, clr_all, hit_inc, miss_inc;
  logic [INDEX_BITS-1:0] line_idx;
  logic [TAG_BITS-1:0]   line_tag;

  always_comb begin
    state_nxt = state;
    rdata_nxt = cpu_rdata;
    ready_nxt = 1'b0;
    busy_nxt  = cpu_busy;
    req_nxt   = mem_req;
    we_nxt    = mem_we;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    line_we   = 1'b0;
    line_idx  = cpu_index;
    line_tag  = cpu_tag;
    line_dat  = cpu_wdata;
    set_valid = 1'b0;
    clr_all   = 1'b0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (flush) begin
          clr_all = 1'b1;
        end else if (cpu_write) begin
          // Write-through: the line is only updated when already resident.
          line_we   = hit;
          hit_inc   = hit;
          miss_inc  = !hit;
          req_nxt   = 1'b1;
          we_nxt    = 1'b1;
          addr_nxt  = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
          wdata_nxt = cpu_wdata;
          busy_nxt  = 1'b1;
          state_nxt = WRITE_MEM;
        end else if (cpu_read) begin
          busy_nxt = 1'b1;
          if (hit) begin
            rdata_nxt = data_store[cpu_index];
            hit_inc   = 1'b1;
            ready_nxt = 1'b1;
            state_nxt = RESPOND;
          end else begin
            miss_inc  = 1'b1;
            req_nxt   = 1'b1;
            we_nxt    = 1'b0;
            addr_nxt  = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
            state_nxt = READ_MEM;
          end
        end
      end
      READ_MEM: begin
        if (mem_ready) begin
          line_we   = 1'b1;
          set_valid = 1'b1;
          line_idx  = mem_index;
          line_tag  = mem_tag;
          line_dat  = mem_rdata;
          rdata_nxt = mem_rdata;
          req_nxt   = 1'b0;
          ready_nxt = 1'b1;
          state_nxt = RESPOND;
        end
      end
      WRITE_MEM: begin
        if (mem_ready) begin
          req_nxt   = 1'b0;
          we_nxt    = 1'b0;
          ready_nxt = 1'b1;
          state_nxt = RESPOND;
        end
      end
      RESPOND: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      cpu_busy   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state     <= state_nxt;
      cpu_rdata <= rdata_nxt;
      cpu_ready <= ready_nxt;
      cpu_busy  <= busy_nxt;
      mem_req   <= req_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      if (clr_all) valid <= '0;
      else if (set_valid) valid[line_idx] <= 1'b1;
      if (hit_inc && hit_count != {CNT_WIDTH{1'b1}}) hit_count <= hit_count + 1'b1;
      if (miss_inc && miss_count != {CNT_WIDTH{1'b1}}) miss_count <= miss_count + 1'b1;
    end
  end

  // Tag and data arrays need no reset: valid bits qualify every lookup.
  always_ff @(posedge clock) begin
    if (!reset && line_we) begin
      tag_store[line_idx]  <= line_tag;
      data_store[line_idx] <= line_dat;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: a default instance plus a CNT_WIDTH=4 twin sharing its inputs.
module tb_dcache_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_read = 1'b0, cpu_write = 1'b0, flush = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic [31:0] cpu_rdata, mem_addr, mem_wdata;
  logic        cpu_ready, cpu_busy, mem_req, mem_we;
  logic [15:0] hit_count, miss_count;

  logic [31:0] cpu_rdata4, mem_addr4, mem_wdata4;
  logic        cpu_ready4, cpu_busy4, mem_req4, mem_we4;
  logic [3:0]  hit_count4, miss_count4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  dcache_controller dut (
    .clock(clock), .reset(reset), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .flush(flush),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_busy(cpu_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  dcache_controller #(.CNT_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .flush(flush),
    .cpu_rdata(cpu_rdata4), .cpu_ready(cpu_ready4), .cpu_busy(cpu_busy4),
    .mem_req(mem_req4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hit_count(hit_count4), .miss_count(miss_count4)
  );

  // Observations of the last CPU operation; ready_k is the cycle (after acceptance) of cpu_ready, 0 on timeout.
  int          req_cycles, ready_k;
  logic        busy_k1, got_we;
  logic [31:0] got_addr, got_wdata, got_rdata;

  // Presents one request, plays a memory that answers on the lat-th cycle of mem_req.
  task automatic cpu_op(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, input logic [31:0] rdata);
    @(negedge clock);
    cpu_write = wr; cpu_read = !wr; cpu_addr = addr; cpu_wdata = wdata;
    req_cycles = 0; ready_k = 0; busy_k1 = 1'b0;
    got_we = 1'b0; got_addr = '0; got_wdata = '0; got_rdata = '0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clock);
      cpu_write = 1'b0; cpu_read = 1'b0; mem_ready = 1'b0;
      if (k == 1) busy_k1 = cpu_busy;
      if (cpu_ready) begin
        ready_k = k; got_rdata = cpu_rdata;
        break;
      end
      if (mem_req) begin
        req_cycles++;
        got_addr = mem_addr; got_we = mem_we; got_wdata = mem_wdata;
        if (req_cycles == lat) begin mem_ready = 1'b1; mem_rdata = rdata; end
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clock); reset = 1'b1;
    repeat (2) @(negedge clock);
    n_vec++; if ({cpu_ready, cpu_busy, mem_req, mem_we} !== 4'b0) begin n_err++; $display("FAIL reset_ctl: got %b want 0000", {cpu_ready, cpu_busy, mem_req, mem_we}); end
    n_vec++; if ({cpu_rdata, mem_addr, mem_wdata} !== 96'd0) begin n_err++; $display("FAIL reset_data: got %h %h %h want 0", cpu_rdata, mem_addr, mem_wdata); end
    n_vec++; if ({hit_count, miss_count} !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %0d %0d want 0 0", hit_count, miss_count); end
    reset = 1'b0;
  endtask

  task automatic test_read_miss;
    cpu_op(1'b0, 32'h40, 32'h0, 3, 32'hDEADBEEF);
    n_vec++; if (busy_k1 !== 1'b1) begin n_err++; $display("FAIL miss_busy: got %b want 1", busy_k1); end
    n_vec++; if (req_cycles != 3) begin n_err++; $display("FAIL miss_req_cycles: got %0d want 3", req_cycles); end
    n_vec++; if ({got_addr, got_we} !== {32'h40, 1'b0}) begin n_err++; $display("FAIL miss_mem_addr_we: got %h %b want 40 0", got_addr, got_we); end
    n_vec++; if (ready_k != 4) begin n_err++; $display("FAIL miss_ready_cycle: got %0d want 4", ready_k); end
    n_vec++; if (got_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL miss_rdata: got %h want deadbeef", got_rdata); end
    n_vec++; if (miss_count !== 16'd1) begin n_err++; $display("FAIL miss_count1: got %0d want 1", miss_count); end
    @(negedge clock);
    n_vec++; if ({cpu_busy, cpu_ready} !== 2'b00) begin n_err++; $display("FAIL after_respond: got %b want 00", {cpu_busy, cpu_ready}); end
  endtask

  task automatic test_read_hit;
    logic [31:0] addrs [2];
    addrs[0] = 32'h40; addrs[1] = 32'h42;
    for (int i = 0; i < 2; i++) begin
      cpu_op(1'b0, addrs[i], 32'h0, 1, 32'hFFFF_FFFF);
      n_vec++; if (ready_k != 1 || req_cycles != 0) begin n_err++; $display("FAIL hit_latency[%0d]: got ready %0d req %0d want 1 0", i, ready_k, req_cycles); end
      n_vec++; if (got_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL hit_rdata[%0d]: got %h want deadbeef", i, got_rdata); end
    end
    n_vec++; if ({hit_count, miss_count} !== {16'd2, 16'd1}) begin n_err++; $display("FAIL hit_counts: got %0d %0d want 2 1", hit_count, miss_count); end
  endtask

  task automatic test_conflict;
    cpu_op(1'b0, 32'h440, 32'h0, 1, 32'hCAFEF00D);
    n_vec++; if (req_cycles != 1 || got_addr !== 32'h440) begin n_err++; $display("FAIL conflict_req: got %0d %h want 1 440", req_cycles, got_addr); end
    n_vec++; if (got_rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL conflict_rdata: got %h want cafef00d", got_rdata); end
    cpu_op(1'b0, 32'h40, 32'h0, 2, 32'hDEADBEEF);
    n_vec++; if (req_cycles != 2 || ready_k != 3) begin n_err++; $display("FAIL evicted_miss: got req %0d ready %0d want 2 3", req_cycles, ready_k); end
    n_vec++; if (miss_count !== 16'd3) begin n_err++; $display("FAIL conflict_miss_count: got %0d want 3", miss_count); end
  endtask

  task automatic test_write;
    cpu_op(1'b1, 32'h40, 32'h12345678, 2, 32'h0);
    n_vec++; if ({got_addr, got_we, got_wdata} !== {32'h40, 1'b1, 32'h12345678}) begin n_err++; $display("FAIL wr_mem: got %h %b %h want 40 1 12345678", got_addr, got_we, got_wdata); end
    n_vec++; if (req_cycles != 2 || ready_k != 3) begin n_err++; $display("FAIL wr_timing: got req %0d ready %0d want 2 3", req_cycles, ready_k); end
    n_vec++; if (got_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_rdata_hold: got %h want deadbeef", got_rdata); end
    n_vec++; if ({hit_count, mem_req, mem_we} !== {16'd3, 2'b00}) begin n_err++; $display("FAIL wr_hit_done: got %0d %b%b want 3 00", hit_count, mem_req, mem_we); end
    cpu_op(1'b0, 32'h40, 32'h0, 1, 32'hFFFF_FFFF);
    n_vec++; if (req_cycles != 0 || got_rdata !== 32'h12345678) begin n_err++; $display("FAIL wr_readback: got req %0d %h want 0 12345678", req_cycles, got_rdata); end
    cpu_op(1'b1, 32'h80, 32'h000055AA, 1, 32'h0);
    n_vec++; if (miss_count !== 16'd4 || hit_count !== 16'd4) begin n_err++; $display("FAIL wr_miss_counts: got %0d %0d want 4 4", hit_count, miss_count); end
    cpu_op(1'b0, 32'h80, 32'h0, 1, 32'h0BADC0DE);
    n_vec++; if (req_cycles != 1 || got_rdata !== 32'h0BADC0DE) begin n_err++; $display("FAIL no_allocate: got req %0d %h want 1 0badc0de", req_cycles, got_rdata); end
    n_vec++; if (miss_count !== 16'd5) begin n_err++; $display("FAIL no_alloc_count: got %0d want 5", miss_count); end
  endtask

  task automatic test_flush;
    @(negedge clock); flush = 1'b1;
    @(negedge clock); flush = 1'b0;
    n_vec++; if ({cpu_ready, cpu_busy, mem_req} !== 3'b000 || {hit_count, miss_count} !== {16'd4, 16'd5}) begin n_err++; $display("FAIL flush_quiet: got %b %0d %0d want 000 4 5", {cpu_ready, cpu_busy, mem_req}, hit_count, miss_count); end
    cpu_op(1'b0, 32'h40, 32'h0, 1, 32'h11112222);
    n_vec++; if (req_cycles != 1 || got_rdata !== 32'h11112222) begin n_err++; $display("FAIL flush_then_miss: got req %0d %h want 1 11112222", req_cycles, got_rdata); end
    @(negedge clock); flush = 1'b1; cpu_read = 1'b1; cpu_addr = 32'h40;
    @(negedge clock); flush = 1'b0; cpu_read = 1'b0;
    n_vec++; if ({cpu_ready, cpu_busy, mem_req} !== 3'b000) begin n_err++; $display("FAIL flush_read_ctl: got %b want 000", {cpu_ready, cpu_busy, mem_req}); end
    @(negedge clock);
    n_vec++; if (cpu_ready !== 1'b0 || {hit_count, miss_count} !== {16'd4, 16'd6}) begin n_err++; $display("FAIL flush_read_cnt: got %b %0d %0d want 0 4 6", cpu_ready, hit_count, miss_count); end
    cpu_op(1'b0, 32'h40, 32'h0, 1, 32'h11112222);
    n_vec++; if (req_cycles != 1 || miss_count !== 16'd7) begin n_err++; $display("FAIL flush_read_invalid: got req %0d miss %0d want 1 7", req_cycles, miss_count); end
  endtask

  task automatic test_reset_midop;
    @(negedge clock); cpu_read = 1'b1; cpu_addr = 32'h100;
    @(negedge clock); cpu_read = 1'b0;
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL midop_req: got %b want 1", mem_req); end
    reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    n_vec++; if ({mem_req, cpu_busy, cpu_ready} !== 3'b000 || {hit_count, miss_count} !== 32'd0) begin n_err++; $display("FAIL midop_reset: got %b %0d %0d want 000 0 0", {mem_req, cpu_busy, cpu_ready}, hit_count, miss_count); end
    cpu_op(1'b0, 32'h40, 32'h0, 1, 32'h77778888);
    n_vec++; if (req_cycles != 1 || miss_count !== 16'd1) begin n_err++; $display("FAIL midop_invalid: got req %0d miss %0d want 1 1", req_cycles, miss_count); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 16; i++) cpu_op(1'b0, 32'h40, 32'h0, 1, 32'h0);
    n_vec++; if (got_rdata !== 32'h77778888 || ready_k != 1) begin n_err++; $display("FAIL sat_last_hit: got %h ready %0d want 77778888 1", got_rdata, ready_k); end
    n_vec++; if (hit_count !== 16'd16) begin n_err++; $display("FAIL sat_wide: got %0d want 16", hit_count); end
    n_vec++; if (hit_count4 !== 4'd15 || miss_count4 !== 4'd1) begin n_err++; $display("FAIL sat_narrow: got %0d %0d want 15 1", hit_count4, miss_count4); end
  endtask

  initial begin
    test_reset;
    test_read_miss;
    test_read_hit;
    test_conflict;
    test_write;
    test_flush;
    test_reset_midop;
    test_saturation;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
